// File: rtl/leaf_pkg.sv
// Packet layout shared by the leaf-group echo slots: field offsets, packet
// struct and the destination-rewrite helper.
package leaf_pkg;

    localparam int PKT_W     = 49;
    localparam int VALID_BIT = PKT_W - 1;
    localparam int ADDR_W    = 5;
    localparam int ADDR_MSB  = PKT_W - 2;
    localparam int ADDR_LSB  = PKT_W - 1 - ADDR_W;
    localparam int PAYLOAD_W = ADDR_LSB;

    typedef struct packed {
        logic                 valid;
        logic [ADDR_W-1:0]    addr;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } slot_state_e;

    function automatic logic pkt_valid(input pkt_t pkt);
        return pkt[VALID_BIT];
    endfunction

    function automatic pkt_t rewrite_addr(input pkt_t pkt, input logic [ADDR_W-1:0] addr);
        pkt_t r_pkt;
        r_pkt = pkt;
        r_pkt[ADDR_MSB:ADDR_LSB] = addr;
        return r_pkt;
    endfunction

endpackage

// File: rtl/leaf_echo_chan.sv
// One loopback slot: IDLE/RUN control, address-rewriting ingress FIFO and a
// resend-aware registered output with a sticky overflow flag.
module leaf_echo_chan #(
    parameter int PKT_W  = leaf_pkg::PKT_W,
    parameter int ADDR_W = leaf_pkg::ADDR_W,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_ap_start,
    input  logic [ADDR_W-1:0] i_ret_addr,
    input  logic [PKT_W-1:0]  i_din,
    input  logic              i_resend,
    output logic [PKT_W-1:0]  o_dout,
    output logic              o_overflow
);
    import leaf_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PKT_W-1:0] r_dout;
    logic             r_overflow;

    logic             w_run;
    logic             w_valid_in;
    logic [PKT_W-1:0] w_push_pkt;
    logic             w_empty;
    logic             w_full;
    logic             w_push_req;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // The struct helpers only describe the default layout; other widths slice directly.
    if (PKT_W == leaf_pkg::PKT_W && ADDR_W == leaf_pkg::ADDR_W) begin : g_pkg_layout
        assign w_valid_in = pkt_valid(pkt_t'(i_din));
        assign w_push_pkt = rewrite_addr(pkt_t'(i_din), i_ret_addr);
    end else begin : g_generic_layout
        assign w_valid_in = i_din[PKT_W-1];
        assign w_push_pkt = {i_din[PKT_W-1], i_ret_addr, i_din[PKT_W-2-ADDR_W:0]};
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_ap_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_push_req = w_run && w_valid_in;
    assign w_pop      = w_run && !i_resend && !w_empty;
    // A full FIFO still accepts a packet when its head leaves on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // NOTE: storage is not reset; pointers and count decide which words are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dout     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Resend freezes the output whether or not it carries a valid packet.
            if (!w_run) begin
                r_dout <= '0;
            end else if (!i_resend) begin
                r_dout <= w_empty ? '0 : r_mem[r_rd_ptr];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_dout     = r_dout;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/leaf_group_echo.sv
// N-slot BFT leaf group where every slot echoes packets back to its own
// return address; slots are independent and only share the clock and reset.
module leaf_group_echo #(
    parameter int                       N_LEAF    = 4,
    parameter int                       PKT_W     = 49,
    parameter int                       ADDR_W    = 5,
    parameter int                       DEPTH     = 8,
    parameter logic [N_LEAF*ADDR_W-1:0] RET_ADDRS = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_LEAF*PKT_W-1:0] din_leaf_bft2interface,
    output logic [N_LEAF*PKT_W-1:0] dout_leaf_interface2bft,
    input  logic [N_LEAF-1:0]       resend,
    input  logic [N_LEAF-1:0]       ap_start,
    output logic [N_LEAF-1:0]       overflow
);

    for (genvar i = 0; i < N_LEAF; i++) begin : g_slot
        leaf_echo_chan #(
            .PKT_W  (PKT_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .i_ap_start (ap_start[i]),
            .i_ret_addr (RET_ADDRS[i*ADDR_W +: ADDR_W]),
            .i_din      (din_leaf_bft2interface[i*PKT_W +: PKT_W]),
            .i_resend   (resend[i]),
            .o_dout     (dout_leaf_interface2bft[i*PKT_W +: PKT_W]),
            .o_overflow (overflow[i])
        );
    end

endmodule
